// File: rtl/sync_debounce_pkg.sv
// Shared constants and helpers for the sync_debounce block.
//
// DEBOUNCE_10MS : default accept count, 10 ms of stable input at 50 MHz.
// cnt_width()   : per-bit counter width, max(1, $clog2(count)).
package sync_debounce_pkg;

  localparam int unsigned DEBOUNCE_10MS = 500000;

  // A count of 1 or 2 still needs one counter bit; $clog2(1) would give 0.
  function automatic int unsigned cnt_width(input int unsigned count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/sync_debounce_bit.sv
// One-bit debouncer: counts consecutive clocks on which the synchronized input
// differs from the stable level and accepts the new level on the COUNT-th one.
//
// Ports:
//   clk   clock
//   rst   synchronous active-low reset
//   i     synchronized input bit
//   o     debounced stable level (INIT at reset)
//   rise  registered one-clock pulse, o went 0->1
//   fall  registered one-clock pulse, o went 1->0
//   take  combinational: this bit accepts a change at the next posedge; the
//         top registers the OR of these into chg so it lines up with rise/fall
module sync_debounce_bit #(
  parameter int unsigned COUNT = 4,
  parameter int unsigned CW    = 2,
  parameter logic        INIT  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i,
  output logic o,
  output logic rise,
  output logic fall,
  output logic take
);

  localparam logic [CW-1:0] CntLast = CW'(COUNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          take_d;

  always_comb begin
    cnt_d  = '0;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    take_d = 1'b0;
    // A match clears the count, so a glitch shorter than COUNT restarts it.
    if (i != lvl_q) begin
      if (cnt_q == CntLast) begin
        lvl_d  = i;
        rise_d = i;
        fall_d = ~i;
        take_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      lvl_q  <= INIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o    = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign take = take_d;

endmodule

// File: rtl/sync_debounce.sv
// Debounce and edge-detect stage for already-synchronized slow inputs
// (console switches, buttons, status lines). Each bit is independent.
//
// Ports:
//   clk   clock, single domain
//   rst   synchronous active-low reset
//   i     [WIDTH] synchronized inputs
//   o     [WIDTH] debounced levels, INIT at reset
//   rise  [WIDTH] one-clock pulse per bit on 0->1 of o
//   fall  [WIDTH] one-clock pulse per bit on 1->0 of o
//   chg   OR of all rise/fall pulses, registered in the same clock
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int unsigned     WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT = '0,
  parameter int unsigned     COUNT = DEBOUNCE_10MS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             chg
);

  localparam int unsigned CW = cnt_width(COUNT);

  logic [WIDTH-1:0] take;
  logic             chg_q, chg_d;

  for (genvar n = 0; n < WIDTH; n++) begin : g_bit
    sync_debounce_bit #(
      .COUNT(COUNT),
      .CW   (CW),
      .INIT (INIT[n])
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .i    (i[n]),
      .o    (o[n]),
      .rise (rise[n]),
      .fall (fall[n]),
      .take (take[n])
    );
  end

  always_comb begin
    chg_d = |take;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign chg = chg_q;

endmodule
